pipe_hazard_ctrl: RTL

//  Next-generation hazard/bypass controller for the 5-stage MIPS32 pipeline; replaces the

---
 rtl/pipe_hazard_ctrl_pkg.sv | 32 +++
 rtl/pipe_hazard_ctrl_fwd_select.sv | 24 ++
 rtl/pipe_hazard_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants, state codes and control-bundle type for the pipeline hazard/bypass controller.
package pipe_hazard_ctrl_pkg;

    localparam int unsigned FWD_W  = 2;
    localparam int unsigned LCNT_W = 3;

    localparam logic [FWD_W-1:0] FWD_RF  = 2'd0;
    localparam logic [FWD_W-1:0] FWD_WB  = 2'd1;
    localparam logic [FWD_W-1:0] FWD_MEM = 2'd2;

    typedef enum logic [1:0] {
        HZ_IDLE    = 2'd0,
        HZ_LDSTALL = 2'd1,
        HZ_MWAIT   = 2'd2
    } hz_state_e;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_bubble;
        logic pipe_hold;
    } hz_ctrl_t;

    // Fixed enable patterns for each pipeline action
    localparam hz_ctrl_t CTRL_RUN    = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0, idex_bubble: 1'b0, pipe_hold: 1'b0};
    localparam hz_ctrl_t CTRL_RESET  = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1, idex_bubble: 1'b1, pipe_hold: 1'b0};
    localparam hz_ctrl_t CTRL_STALL  = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0, idex_bubble: 1'b1, pipe_hold: 1'b0};
    localparam hz_ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0, idex_bubble: 1'b0, pipe_hold: 1'b1};
    localparam hz_ctrl_t CTRL_FLUSH  = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1, idex_bubble: 1'b1, pipe_hold: 1'b0};

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_select.sv
// Per-operand bypass select: the youngest producer (EX/MEM) wins over MEM/WB; $zero never forwards.
module pipe_hazard_ctrl_fwd_select
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] src,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_regwrite,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_regwrite,
    output logic [FWD_W-1:0]  sel
);

    always_comb begin
        sel = FWD_RF;
        if (mem_regwrite && (mem_rd != '0) && (mem_rd == src)) begin
            sel = FWD_MEM;
        end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == src)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/bypass controller across ID/EX/MEM: forwarding, load-use stall, branch flush, memory freeze.
// Optional saturating perf counters are built when HAZ_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_regwrite,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_regwrite,
    input  logic              branch_taken,
    input  logic              dmem_req,
    input  logic              dmem_ready,
    output logic [FWD_W-1:0]  fwd_a,
    output logic [FWD_W-1:0]  fwd_b,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              pipe_hold,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  freeze_cnt
);

    hz_state_e         state, state_nxt;
    logic [LCNT_W-1:0] lcnt, lcnt_nxt;
    hz_ctrl_t          ctrl;
    logic [FWD_W-1:0]  sel_a, sel_b;
    logic              luse, mwait_req;

    pipe_hazard_ctrl_fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
        .src(ex_rs), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .sel(sel_a)
    );

    pipe_hazard_ctrl_fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
        .src(ex_rt), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .sel(sel_b)
    );

    assign fwd_a = reset ? FWD_RF : sel_a;
    assign fwd_b = reset ? FWD_RF : sel_b;

    assign luse = ex_memread && (ex_rd != '0) &&
                  ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
    assign mwait_req = dmem_req && !dmem_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= HZ_IDLE;
            lcnt  <= '0;
        end else begin
            state <= state_nxt;
            lcnt  <= lcnt_nxt;
        end
    end

    // Priority in every state: memory wait, then branch flush, then load-use.
    // lcnt survives a freeze so an interrupted load-use stall resumes afterwards.
    always_comb begin
        state_nxt = state;
        lcnt_nxt  = lcnt;
        ctrl      = CTRL_RUN;
        if (reset) begin
            ctrl      = CTRL_RESET;
            state_nxt = HZ_IDLE;
            lcnt_nxt  = '0;
        end else begin
            case (state)
                HZ_IDLE: begin
                    if (mwait_req) begin
                        ctrl      = CTRL_FREEZE;
                        state_nxt = HZ_MWAIT;
                    end else if (branch_taken) begin
                        ctrl = CTRL_FLUSH;
                    end else if (luse) begin
                        ctrl = CTRL_STALL;
                        if (LOAD_LAT > 1) begin
                            state_nxt = HZ_LDSTALL;
                            lcnt_nxt  = LCNT_W'(LOAD_LAT - 1);
                        end
                    end
                end
                HZ_LDSTALL: begin
                    if (mwait_req) begin
                        ctrl      = CTRL_FREEZE;
                        state_nxt = HZ_MWAIT;
                    end else if (branch_taken) begin
                        ctrl      = CTRL_FLUSH;
                        state_nxt = HZ_IDLE;
                        lcnt_nxt  = '0;
                    end else begin
                        ctrl = CTRL_STALL;
                        if (lcnt <= LCNT_W'(1)) begin
                            state_nxt = HZ_IDLE;
                            lcnt_nxt  = '0;
                        end else begin
                            lcnt_nxt = lcnt - LCNT_W'(1);
                        end
                    end
                end
                HZ_MWAIT: begin
                    ctrl = CTRL_FREEZE;
                    if (!mwait_req) begin
                        if (lcnt > LCNT_W'(1)) begin
                            state_nxt = HZ_LDSTALL;
                        end else begin
                            state_nxt = HZ_IDLE;
                            lcnt_nxt  = '0;
                        end
                    end
                end
                default: begin
                    state_nxt = HZ_IDLE;
                    lcnt_nxt  = '0;
                end
            endcase
        end
    end

    assign pc_write    = ctrl.pc_write;
    assign ifid_write  = ctrl.ifid_write;
    assign ifid_flush  = ctrl.ifid_flush;
    assign idex_bubble = ctrl.idex_bubble;
    assign pipe_hold   = ctrl.pipe_hold;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, freeze_q;

    // Saturating event counters for load-use stall and memory-freeze cycles
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_q  <= '0;
            freeze_q <= '0;
        end else begin
            if ((ctrl == CTRL_STALL) && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if ((ctrl == CTRL_FREEZE) && (freeze_q != '1)) begin
                freeze_q <= freeze_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt  = stall_q;
    assign freeze_cnt = freeze_q;
`else
    assign stall_cnt  = '0;
    assign freeze_cnt = '0;
`endif

endmodule
